operand_stage: RTL and testbench

- ID→EX boundary stage: drives register-file read addresses from the decoded instruction, takes the two combinational read values, and applies EX/MEM/WB bypassing.
- Detects load-use hazards and registers the resolved operands into the ID/EX pipeline register.
- Valid/ready handshake on both sides; branch-resolution flush input.

---
 rtl/operand_stage_pkg.sv | 18 +
 rtl/operand_stage_forward_mux.sv | 47 ++++
 rtl/operand_stage.sv | 140 ++++++++++++++
 tb/tb_operand_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/operand_stage_pkg.sv
// Shared types for the ID->EX operand stage: data word, register address, bypass source select.
package operand_stage_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_AW = 5;

    typedef logic [WORD_W-1:0] Word;
    typedef logic [REG_AW-1:0] RegAddress;

    typedef enum logic [2:0] {
        FWD_ZERO,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_RF
    } FwdSel;

endpackage

// File: rtl/operand_stage_forward_mux.sv
// Per-source bypass network: picks x0, EX, MEM, WB or register-file data for one read address.
module forward_mux
    import operand_stage_pkg::*;
(
    input  RegAddress addr,
    input  RegAddress ex_rd,
    input  logic      ex_we,
    input  logic      ex_is_load,
    input  Word       ex_result,
    input  RegAddress mem_rd,
    input  logic      mem_we,
    input  Word       mem_result,
    input  RegAddress wb_rd,
    input  logic      wb_we,
    input  Word       wb_data,
    input  Word       rf_data,
    output FwdSel     sel,
    output Word       operand
);

    // Youngest producer wins; a load in EX has no data yet and is never a source.
    always_comb begin
        sel = FWD_RF;
        if (addr == '0) begin
            sel = FWD_ZERO;
        end else if (ex_we && (ex_rd == addr) && !ex_is_load) begin
            sel = FWD_EX;
        end else if (mem_we && (mem_rd == addr)) begin
            sel = FWD_MEM;
        end else if (wb_we && (wb_rd == addr)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        operand = '0;
        case (sel)
            FWD_ZERO: operand = '0;
            FWD_EX:   operand = ex_result;
            FWD_MEM:  operand = mem_result;
            FWD_WB:   operand = wb_data;
            FWD_RF:   operand = rf_data;
            default:  operand = '0;
        endcase
    end

endmodule

// File: rtl/operand_stage.sv
// ID/EX operand stage: bypassing, load-use bubble insertion and the ID/EX pipeline register.
// Optional stall_count output is built when OPERAND_STAGE_STALL_CNT_EN is defined.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_we,
    input  logic            in_is_load,
    output logic [4:0]      rf_addr1,
    output logic [4:0]      rf_addr2,
    input  logic [XLEN-1:0] rf_out1,
    input  logic [XLEN-1:0] rf_out2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [XLEN-1:0] ex_result,
    input  logic [4:0]      mem_rd,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_is_load
`ifdef OPERAND_STAGE_STALL_CNT_EN
    ,
    output logic [31:0]     stall_count
`endif
);

    FwdSel sel1;
    FwdSel sel2;
    Word   op1;
    Word   op2;
    logic  hazard;
    logic  advance;

    assign rf_addr1 = in_rs1;
    assign rf_addr2 = in_rs2;

    forward_mux u_fwd1 (
        .addr       (RegAddress'(in_rs1)),
        .ex_rd      (RegAddress'(ex_rd)),
        .ex_we      (ex_we),
        .ex_is_load (ex_is_load),
        .ex_result  (Word'(ex_result)),
        .mem_rd     (RegAddress'(mem_rd)),
        .mem_we     (mem_we),
        .mem_result (Word'(mem_result)),
        .wb_rd      (RegAddress'(wb_rd)),
        .wb_we      (wb_we),
        .wb_data    (Word'(wb_data)),
        .rf_data    (Word'(rf_out1)),
        .sel        (sel1),
        .operand    (op1)
    );

    forward_mux u_fwd2 (
        .addr       (RegAddress'(in_rs2)),
        .ex_rd      (RegAddress'(ex_rd)),
        .ex_we      (ex_we),
        .ex_is_load (ex_is_load),
        .ex_result  (Word'(ex_result)),
        .mem_rd     (RegAddress'(mem_rd)),
        .mem_we     (mem_we),
        .mem_result (Word'(mem_result)),
        .wb_rd      (RegAddress'(wb_rd)),
        .wb_we      (wb_we),
        .wb_data    (Word'(wb_data)),
        .rf_data    (Word'(rf_out2)),
        .sel        (sel2),
        .operand    (op2)
    );

    // Load in EX whose result is read by the incoming instruction: hold it one cycle.
    assign hazard  = in_valid && ex_we && ex_is_load && (ex_rd != 5'd0) &&
                     ((in_use_rs1 && (ex_rd == in_rs1)) || (in_use_rs2 && (ex_rd == in_rs2)));
    assign advance = !out_valid || out_ready;
    assign in_ready = flush || (advance && !hazard);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_is_load <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            if (hazard || !in_valid) begin
                out_valid <= 1'b0;
            end else begin
                out_valid   <= 1'b1;
                out_pc      <= in_pc;
                out_op1     <= XLEN'(op1);
                out_op2     <= XLEN'(op2);
                out_rd      <= in_rd;
                out_rd_we   <= in_rd_we;
                out_is_load <= in_is_load;
            end
        end
    end

`ifdef OPERAND_STAGE_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (!flush && advance && hazard) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

    // The bypass network must never pick a load still in EX as a data source.
    a_no_load_fwd: assert property (@(posedge clk) disable iff (!reset)
        !(ex_is_load && ((sel1 == FWD_EX) || (sel2 == FWD_EX))));

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: directed scenarios plus randomized traffic against a cycle model.
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use_rs1, in_use_rs2, in_rd_we, in_is_load;
    logic [4:0]  rf_addr1, rf_addr2;
    logic [31:0] rf_out1, rf_out2;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic        ex_we, ex_is_load, mem_we, wb_we;
    logic [31:0] ex_result, mem_result, wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_op1, out_op2;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_is_load;
`ifdef OPERAND_STAGE_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        we;
        logic        ld;
        logic [31:0] stall;
    } exp_t;

    exp_t q[$];
    exp_t m;
    exp_t e;

    operand_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_out1(rf_out1), .rf_out2(rf_out2),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_result(ex_result),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_is_load(out_is_load)
`ifdef OPERAND_STAGE_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural bypass rule: newest non-load producer of the register, else register file.
    function automatic logic [31:0] ref_op(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        if (ex_we && ex_rd == a && !ex_is_load) return ex_result;
        if (mem_we && mem_rd == a) return mem_result;
        if (wb_we && wb_rd == a) return wb_data;
        return rf;
    endfunction

    task automatic clear_inputs();
        in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_use_rs1 = 0; in_use_rs2 = 0;
        in_rd = 0; in_rd_we = 0; in_is_load = 0; rf_out1 = 0; rf_out2 = 0;
        ex_rd = 0; ex_we = 0; ex_is_load = 0; ex_result = 0;
        mem_rd = 0; mem_we = 0; mem_result = 0; wb_rd = 0; wb_we = 0; wb_data = 0;
        flush = 0; out_ready = 1;
    endtask

    // Inputs already driven after a negedge: check handshake, advance model, queue next-edge state.
    task automatic step();
        logic hz, adv, rdy;
        #1;
        hz  = in_valid && ex_we && ex_is_load && (ex_rd != 0) &&
              ((in_use_rs1 && ex_rd == in_rs1) || (in_use_rs2 && ex_rd == in_rs2));
        adv = !m.v || out_ready;
        rdy = flush || (adv && !hz);
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("rf_addr", {54'd0, rf_addr1, rf_addr2}, {54'd0, in_rs1, in_rs2});
        if (flush) begin
            m.v = 0;
        end else if (adv) begin
            if (hz) begin
                m.v = 0;
                m.stall = m.stall + 32'd1;
            end else if (in_valid) begin
                m.v = 1; m.pc = in_pc; m.rd = in_rd; m.we = in_rd_we; m.ld = in_is_load;
                m.op1 = ref_op(in_rs1, rf_out1);
                m.op2 = ref_op(in_rs2, rf_out2);
            end else begin
                m.v = 0;
            end
        end
        q.push_back(m);
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd);
        in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
        in_use_rs1 = u1; in_use_rs2 = u2; in_rd = rd; in_rd_we = 1; in_is_load = 0;
    endtask

    always @(posedge clk) begin
        #1;
        if (reset && q.size() > 0) begin
            e = q.pop_front();
            chk("out_valid", 64'(out_valid), 64'(e.v));
            if (e.v) begin
                chk("out_pc", 64'(out_pc), 64'(e.pc));
                chk("out_op1", 64'(out_op1), 64'(e.op1));
                chk("out_op2", 64'(out_op2), 64'(e.op2));
                chk("out_ctl", {57'd0, out_rd, out_rd_we, out_is_load}, {57'd0, e.rd, e.we, e.ld});
            end
`ifdef OPERAND_STAGE_STALL_CNT_EN
            chk("stall_count", 64'(stall_count), 64'(e.stall));
`endif
        end
    end

    initial begin
        m = '{default: '0};
        clear_inputs();
        reset = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_fields", {out_pc, out_op1 ^ out_op2}, 64'd0);
        reset = 1;

        // Bypass priority on rs1=5
        @(negedge clk); issue(32'h100, 5, 0, 1, 0, 1); rf_out1 = 1;
        wb_we = 1; wb_rd = 5; wb_data = 3; mem_we = 1; mem_rd = 5; mem_result = 7;
        ex_we = 1; ex_rd = 5; ex_result = 9; step();
        @(posedge clk); #2; chk("prio_ex", 64'(out_op1), 64'd9);
        @(negedge clk); ex_we = 0; step();
        @(posedge clk); #2; chk("prio_mem", 64'(out_op1), 64'd7);
        @(negedge clk); mem_we = 0; step();
        @(posedge clk); #2; chk("prio_wb", 64'(out_op1), 64'd3);
        @(negedge clk); wb_we = 0; step();
        @(posedge clk); #2; chk("prio_rf", 64'(out_op1), 64'd1);

        // x0 never forwards
        @(negedge clk); clear_inputs(); issue(32'h104, 0, 0, 1, 0, 2);
        ex_we = 1; ex_rd = 0; ex_result = 32'hDEAD; rf_out1 = 32'h55; step();
        @(posedge clk); #2; chk("x0", 64'(out_op1), 64'd0);

        // Load-use: one bubble, then operand from MEM
        @(negedge clk); clear_inputs(); issue(32'h108, 1, 6, 0, 1, 3);
        ex_we = 1; ex_is_load = 1; ex_rd = 6; ex_result = 32'hBAD; step();
        @(posedge clk); #2; chk("lu_bubble", 64'(out_valid), 64'd0);
        @(negedge clk); ex_we = 0; ex_is_load = 0; mem_we = 1; mem_rd = 6; mem_result = 42; step();
        @(posedge clk); #2; chk("lu_fwd", {31'd0, out_valid, out_op2}, {31'd0, 1'b1, 32'd42});

        // Back-pressure for three cycles
        @(negedge clk); clear_inputs(); issue(32'h10C, 2, 3, 1, 1, 4); rf_out1 = 11; rf_out2 = 12; step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); issue(32'h110, 4, 5, 1, 1, 7); rf_out1 = 21; rf_out2 = 22;
            out_ready = 0; step();
        end
        @(negedge clk); out_ready = 1; step();
        @(posedge clk); #2; chk("bp_accept", 64'(out_pc), 64'h110);

        // Flush while hazard is pending
        @(negedge clk); clear_inputs(); issue(32'h114, 8, 0, 1, 0, 9);
        ex_we = 1; ex_is_load = 1; ex_rd = 8; flush = 1; step();
        @(negedge clk); clear_inputs(); step();

        // Asynchronous reset mid-stream
        @(negedge clk); issue(32'h118, 1, 2, 1, 1, 3); rf_out1 = 5; rf_out2 = 6; step();
        @(negedge clk); clear_inputs(); out_ready = 0; reset = 0; #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_fields", {out_pc ^ out_op1, 22'd0, out_op2[4:0] | out_rd, out_rd_we, out_is_load,
                            out_op2 != 0}, 64'd0);
        m = '{default: '0};
        @(negedge clk); reset = 1; out_ready = 1;

        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_pc = $urandom; in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
            in_use_rs1 = 1'($urandom); in_use_rs2 = 1'($urandom);
            in_rd = 5'($urandom); in_rd_we = 1'($urandom); in_is_load = 1'($urandom);
            rf_out1 = $urandom; rf_out2 = $urandom;
            ex_rd = 5'($urandom_range(0, 7)); ex_we = 1'($urandom);
            ex_is_load = ($urandom_range(0, 2) == 0); ex_result = $urandom;
            mem_rd = 5'($urandom_range(0, 7)); mem_we = 1'($urandom); mem_result = $urandom;
            wb_rd = 5'($urandom_range(0, 7)); wb_we = 1'($urandom); wb_data = $urandom;
            flush = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        @(negedge clk); clear_inputs(); step();
        @(posedge clk); #3;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
